// File: rtl/cic_pkg.sv
// Shared definitions for the multi-channel CIC decimator.
//   clamp_rate : maps a requested decimation factor onto 1..max_rate.
//   round_sat  : rounds half-up, shifts arithmetically right and saturates to out_bits.
package cic_pkg;

  localparam int unsigned CalcWidth = 64;

  typedef struct packed {
    logic signed [CalcWidth-1:0] value;
    logic                        sat;
  } round_sat_t;

  function automatic int unsigned clamp_rate(int unsigned rate, int unsigned max_rate);
    if (rate == 0) return 1;
    if (rate > max_rate) return max_rate;
    return rate;
  endfunction

  // Rounding is done at CalcWidth so the +2^(shift-1) can never wrap.
  function automatic round_sat_t round_sat(logic signed [CalcWidth-1:0] value,
                                           int unsigned shift, int unsigned out_bits);
    round_sat_t                  res;
    logic signed [CalcWidth-1:0] v;
    logic signed [CalcWidth-1:0] hi;
    logic signed [CalcWidth-1:0] lo;
    v = value;
    if (shift > 0) v = v + (64'sd1 <<< (shift - 1));
    v = v >>> shift;
    hi = (64'sd1 <<< (out_bits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_bits - 1));
    res.sat   = 1'b0;
    res.value = v;
    if (v > hi) begin
      res.value = hi;
      res.sat   = 1'b1;
    end else if (v < lo) begin
      res.value = lo;
      res.sat   = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/cic_channel.sv
// One CIC channel: FilterOrder cascaded integrators followed by FilterOrder combs.
//   accept   : input word accepted this cycle, integrators update
//   dump     : frame completes this cycle, comb delay lines shift
//   sample   : signed input word
//   comb_out : combinational comb result built from this cycle's integrator values
module cic_channel
  import cic_pkg::*;
#(
  parameter int unsigned InputLengthBits    = 12,
  parameter int unsigned InternalLengthBits = 30,
  parameter int unsigned FilterOrder        = 3,
  parameter int unsigned DelayLength        = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear,
  input  logic                                 accept,
  input  logic                                 dump,
  input  logic signed [InputLengthBits-1:0]    sample,
  output logic signed [InternalLengthBits-1:0] comb_out
);

  typedef logic signed [InternalLengthBits-1:0] word_t;

  word_t integ_q [FilterOrder];
  word_t integ_d [FilterOrder];
  word_t dly_q   [FilterOrder][DelayLength];
  word_t comb_x  [FilterOrder+1];

  // All arithmetic wraps modulo 2^InternalLengthBits; the comb undoes integrator overflow.
  always_comb begin
    integ_d    = integ_q;
    integ_d[0] = integ_q[0] + word_t'(sample);
    for (int k = 1; k < FilterOrder; k++) begin
      integ_d[k] = integ_q[k] + integ_d[k-1];
    end
    comb_x[0] = integ_d[FilterOrder-1];
    for (int j = 0; j < FilterOrder; j++) begin
      comb_x[j+1] = comb_x[j] - dly_q[j][DelayLength-1];
    end
  end

  assign comb_out = comb_x[FilterOrder];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int k = 0; k < FilterOrder; k++) begin
        integ_q[k] <= '0;
        for (int i = 0; i < DelayLength; i++) dly_q[k][i] <= '0;
      end
    end else begin
      if (accept) integ_q <= integ_d;
      if (dump) begin
        for (int j = 0; j < FilterOrder; j++) begin
          dly_q[j][0] <= comb_x[j];
          for (int i = 1; i < DelayLength; i++) dly_q[j][i] <= dly_q[j][i-1];
        end
      end
    end
  end

endmodule

// File: rtl/cic_decimator_mc.sv
// Multi-channel CIC decimator with runtime rate, output shift and valid/ready handshakes.
//   clk, rst_n (sync, active low), clear (sync state flush)
//   rate      : requested decimation factor, latched at the start of each frame
//   shift     : rounding arithmetic right shift applied before saturation
//   in/in_valid/in_ready    : packed per-channel input words
//   out/out_valid/out_ready : packed per-channel decimated words, out_sat per channel
module cic_decimator_mc
  import cic_pkg::*;
#(
  parameter int unsigned NumChannels        = 2,
  parameter int unsigned InputLengthBits    = 12,
  parameter int unsigned MaxDecimation      = 64,
  parameter int unsigned DelayLength        = 1,
  parameter int unsigned FilterOrder        = 3,
  parameter int unsigned InternalLengthBits = 30,
  parameter int unsigned OutputLengthBits   = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      clear,
  input  logic [$clog2(MaxDecimation+1)-1:0]        rate,
  input  logic [$clog2(InternalLengthBits)-1:0]     shift,
  input  logic [NumChannels*InputLengthBits-1:0]    in,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  output logic [NumChannels*OutputLengthBits-1:0]   out,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [NumChannels-1:0]                    out_sat
);

  localparam int unsigned RateWidth = $clog2(MaxDecimation + 1);

  logic [RateWidth-1:0]                    phase_q;
  logic [RateWidth-1:0]                    r_active_q;
  logic [RateWidth-1:0]                    r_eff;
  logic                                    last;
  logic                                    accept;
  logic                                    load;
  logic                                    out_valid_q;
  logic [NumChannels*OutputLengthBits-1:0] out_q;
  logic [NumChannels*OutputLengthBits-1:0] out_d;
  logic [NumChannels-1:0]                  out_sat_q;
  logic [NumChannels-1:0]                  sat_d;

  // At phase 0 the frame length is the rate that this accept will latch, so the stall
  // decision already sees a change to R=1 and never lets a completing word overwrite out.
  always_comb begin
    r_eff    = (phase_q == '0) ? RateWidth'(clamp_rate(32'(rate), MaxDecimation)) : r_active_q;
    last     = (phase_q == r_eff - RateWidth'(1));
    in_ready = rst_n && !(out_valid_q && !out_ready && last);
    accept   = in_valid && in_ready && !clear;
    load     = accept && last;
  end

  for (genvar c = 0; c < NumChannels; c++) begin : g_chan
    logic signed [InternalLengthBits-1:0] comb_out;
    logic signed [CalcWidth-1:0]          comb_wide;
    round_sat_t                           rs;

    cic_channel #(
      .InputLengthBits   (InputLengthBits),
      .InternalLengthBits(InternalLengthBits),
      .FilterOrder       (FilterOrder),
      .DelayLength       (DelayLength)
    ) u_channel (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (clear),
      .accept  (accept),
      .dump    (load),
      .sample  (in[c*InputLengthBits +: InputLengthBits]),
      .comb_out(comb_out)
    );

    assign comb_wide = CalcWidth'(comb_out);
    assign rs        = round_sat(comb_wide, 32'(shift), OutputLengthBits);
    assign out_d[c*OutputLengthBits +: OutputLengthBits] = rs.value[OutputLengthBits-1:0];
    assign sat_d[c]  = rs.sat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q     <= '0;
      r_active_q  <= RateWidth'(1);
      out_valid_q <= 1'b0;
      out_q       <= '0;
      out_sat_q   <= '0;
    end else if (clear) begin
      phase_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        phase_q <= last ? '0 : phase_q + RateWidth'(1);
        if (phase_q == '0) r_active_q <= r_eff;
      end
      if (load) begin
        out_valid_q <= 1'b1;
        out_q       <= out_d;
        out_sat_q   <= sat_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out       = out_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;

endmodule

// File: doc/cic_decimator_mc.md
CIC_DECIMATOR_MC -- requirements
Module: cic_decimator_mc

Interface
REQ-001 SHALL have parameter NumChannels, default 2: parallel channels sharing one decimation phase.
REQ-002 SHALL have parameter InputLengthBits, default 12: signed input word width per channel.
REQ-003 SHALL have parameter MaxDecimation, default 64: largest legal runtime decimation factor R.
REQ-004 SHALL have parameter DelayLength, default 1: comb differential delay, in decimated samples.
REQ-005 SHALL have parameter FilterOrder, default 3: number of integrator stages and comb stages.
REQ-006 SHALL have parameter InternalLengthBits, default 30: integrator and comb width; must be at least InputLengthBits+ceil(FilterOrder*log2(DelayLength*MaxDecimation)).
REQ-007 SHALL have parameter OutputLengthBits, default 16: signed output word width per channel.
REQ-008 SHALL have port clk, input, 1 bit: the single clock; one clock, all logic on rising edge.
REQ-009 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-010 SHALL have port clear, input, 1 bit: synchronous flush of filter state without a reset.
REQ-011 SHALL have port rate, input, $clog2(MaxDecimation+1) bits: requested decimation factor R.
REQ-012 SHALL have port shift, input, $clog2(InternalLengthBits) bits: arithmetic right-shift applied at the output.
REQ-013 SHALL have port in, input, NumChannels*InputLengthBits bits: channel c occupies slice c, two's complement.
REQ-014 SHALL have ports in_valid (input, 1 bit) and in_ready (output, 1 bit): input handshake; a word is accepted when both are high.
REQ-015 SHALL have port out, output, NumChannels*OutputLengthBits bits: the decimated samples, channel c in slice c.
REQ-016 SHALL have ports out_valid (output, 1 bit) and out_ready (input, 1 bit): output handshake.
REQ-017 SHALL have port out_sat, output, NumChannels bits: bit c is high when channel c saturated in the current output word.

Function
REQ-018 On accept, SHALL update all integrators of every channel in cascade within the same cycle: stage k+1 adds stage k's new value; wrap-around, no saturation.
REQ-019 SHALL hold a phase counter 0..R_active-1 that increments on each accept and wraps to 0.
REQ-020 SHALL latch R_active from rate only on an accept while the phase is 0; rate=0 is treated as 1 and rate>MaxDecimation is clamped to MaxDecimation.
REQ-021 On the accept that wraps the phase, SHALL run the last integrator value through FilterOrder combs of delay DelayLength (wrap arithmetic) in that cycle.
REQ-022 SHALL round the comb result by adding 2^(shift-1) when shift>0, then shift arithmetically right by shift.
REQ-023 SHALL saturate the shifted result to OutputLengthBits, setting the matching out_sat bit when it does.
REQ-024 SHALL register the result into out, with out_valid high on the next cycle; latency is one cycle from the R-th accept.
REQ-025 SHALL hold out, out_sat and out_valid stable until out_valid&&out_ready, then drop out_valid unless a new word loads in the same cycle.
REQ-026 SHALL drive in_ready low only when the output is occupied without out_ready and the phase is R_active-1; no word is ever dropped.
REQ-027 SHALL, on clear=1, zero integrators, comb delays and phase and drop out_valid next cycle; clear overrides a simultaneous accept.
REQ-028 SHALL, with R_active=1, produce one output per accepted input, and the pipeline SHALL still stall correctly under backpressure.

Reset
REQ-029 On rst_n=0 at a clock edge, SHALL zero all integrators, comb delays, phase, out and out_sat, deassert out_valid, and set R_active=1.
REQ-030 SHALL hold in_ready low while rst_n=0; reset in mid-frame discards the partial frame.

Structure
REQ-031 Package cic_pkg SHALL hold the rate clamp function and the shared round/saturate function.
REQ-032 Sub-module cic_channel SHALL implement one channel's integrators and combs; NumChannels instances share the phase counter and handshake.

Verification
REQ-033 Bench SHALL drive a step input 1 on both channels with R=4, order 3, D=1, shift=0 -> outputs settle at 64 after 3 outputs.
REQ-034 Bench SHALL hold out_ready low for 20 cycles with R=2 -> in_ready low after phase 1, one stall, no lost or duplicated word.
REQ-035 Bench SHALL change rate from 4 to 8 mid-frame -> the change takes effect only at the next phase-0 accept.
REQ-036 Bench SHALL drive the max positive input with R=64, shift=0, OutputLengthBits=16 -> out=32767 and the out_sat bits set.
REQ-037 Bench SHALL assert clear and rst_n=0 mid-frame -> out_valid=0 next cycle, and the next frame's output matches a fresh-start model.
REQ-038 Bench SHALL compare random input with R=1..MaxDecimation and shift 0..17 against a bit-exact reference model -> zero mismatches.
